// File: rtl/chunked_comparator.sv
// Multi-cycle magnitude comparator: scans two WIDTH-bit operands CHUNK bits per cycle,
// most-significant chunk first, stopping at the first differing chunk.
module chunked_comparator #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs1d,
  input  logic [WIDTH-1:0] rs2d,
  input  logic             s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             lt
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;

  assign a_chunk = a_q[WIDTH-1 -: CHUNK];
  assign b_chunk = b_q[WIDTH-1 -: CHUNK];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    lt_d    = lt_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = rs1d;
          b_d   = rs2d;
          // Flipping the sign bits maps two's complement order onto unsigned order.
          if (s) begin
            a_d[WIDTH-1] = ~rs1d[WIDTH-1];
            b_d[WIDTH-1] = ~rs2d[WIDTH-1];
          end
          idx_d   = IDXW'(NCHUNK - 1);
          state_d = CMP;
        end
      end

      CMP: begin
        if (a_chunk != b_chunk) begin
          lt_d    = (a_chunk < b_chunk);
          eq_d    = 1'b0;
          state_d = DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          lt_d    = 1'b0;
          state_d = DONE;
        end else begin
          a_d   = a_q << CHUNK;
          b_d   = b_q << CHUNK;
          idx_d = idx_q - 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign eq        = eq_q;
  assign lt        = lt_q;

endmodule

// File: tb/tb_chunked_comparator.sv
// Directed and randomised checks of chunked_comparator against an arithmetic reference
// model; two extra instances cover the CHUNK==WIDTH and CHUNK==1 corners.
module tb_chunked_comparator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_valid_aux;
  logic        out_ready;
  logic        s;
  logic [31:0] rs1d;
  logic [31:0] rs2d;

  logic in_ready, out_valid, eq, lt;
  logic in_ready_w, out_valid_w, eq_w, lt_w;
  logic in_ready_b, out_valid_b, eq_b, lt_b;

  int   total = 0;
  int   bad   = 0;
  int   lat;
  logic got_eq, got_lt;

  always #5 clk = ~clk;

  chunked_comparator #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1d(rs1d), .rs2d(rs2d), .s(s), .out_valid(out_valid), .out_ready(out_ready),
    .eq(eq), .lt(lt)
  );

  chunked_comparator #(.WIDTH(32), .CHUNK(32)) dut_w (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_aux), .in_ready(in_ready_w),
    .rs1d(rs1d), .rs2d(rs2d), .s(s), .out_valid(out_valid_w), .out_ready(1'b1),
    .eq(eq_w), .lt(lt_w)
  );

  chunked_comparator #(.WIDTH(32), .CHUNK(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_aux), .in_ready(in_ready_b),
    .rs1d(rs1d), .rs2d(rs2d), .s(s), .out_valid(out_valid_b), .out_ready(1'b1),
    .eq(eq_b), .lt(lt_b)
  );

  // Reference model: plain signed/unsigned arithmetic plus a count of leading equal bytes.
  function automatic logic ref_lt(input logic [31:0] a, input logic [31:0] b, input logic sg);
    if (sg) return ($signed(a) < $signed(b));
    return (a < b);
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    for (int i = 3; i >= 0; i--) begin
      if (((a >> (8 * i)) & 32'hFF) == ((b >> (8 * i)) & 32'hFF)) n++;
      else break;
    end
    return (n + 1 > 4) ? 4 : n + 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one operand pair, measures cycles from accept to out_valid; leaves result held.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sg);
    @(negedge clk);
    checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
    rs1d = a; rs2d = b; s = sg; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    checkOutput("out_valid_seen", 32'(out_valid), 32'd1);
    got_eq = eq;
    got_lt = lt;
  endtask

  task automatic releaseResult(input int stall);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_eq_stable", 32'(eq), 32'(got_eq));
      checkOutput("stall_lt_stable", 32'(lt), 32'(got_lt));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    checkOutput("release_out_valid", 32'(out_valid), 32'd0);
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic checkTxn(input logic [31:0] a, input logic [31:0] b, input logic sg,
                          input int stall);
    applyStimulus(a, b, sg);
    checkOutput("eq", 32'(got_eq), 32'(a == b));
    checkOutput("lt", 32'(got_lt), 32'(ref_lt(a, b, sg)));
    checkOutput("latency", 32'(lat), 32'(ref_lat(a, b)));
    releaseResult(stall);
  endtask

  // Runs the CHUNK=32 and CHUNK=1 instances on one equal operand pair.
  task automatic checkAuxEqual(input logic [31:0] v, input logic sg);
    int   lat_w = 0;
    int   lat_b = 0;
    logic eq_wc = 1'b0, lt_wc = 1'b1, eq_bc = 1'b0, lt_bc = 1'b1;
    @(negedge clk);
    checkOutput("aux_w_in_ready", 32'(in_ready_w), 32'd1);
    checkOutput("aux_b_in_ready", 32'(in_ready_b), 32'd1);
    rs1d = v; rs2d = v; s = sg; in_valid_aux = 1'b1;
    @(posedge clk);
    #1 in_valid_aux = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid_w && lat_w == 0) begin lat_w = c; eq_wc = eq_w; lt_wc = lt_w; end
      if (out_valid_b && lat_b == 0) begin lat_b = c; eq_bc = eq_b; lt_bc = lt_b; end
    end
    checkOutput("chunk32_latency", 32'(lat_w), 32'd1);
    checkOutput("chunk32_eq", 32'(eq_wc), 32'd1);
    checkOutput("chunk32_lt", 32'(lt_wc), 32'd0);
    checkOutput("chunk1_latency", 32'(lat_b), 32'd32);
    checkOutput("chunk1_eq", 32'(eq_bc), 32'd1);
    checkOutput("chunk1_lt", 32'(lt_bc), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    reset_n = 1'b0; in_valid = 1'b0; in_valid_aux = 1'b0; out_ready = 1'b0;
    s = 1'b0; rs1d = '0; rs2d = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_eq", 32'(eq), 32'd0);
    checkOutput("reset_lt", 32'(lt), 32'd0);
    reset_n = 1'b1;

    $display("[TB] directed compares");
    checkTxn(32'h0000_0001, 32'h0000_0002, 1'b0, 0);
    checkTxn(32'h0200_0000, 32'h0100_0000, 1'b0, 0);
    checkTxn(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1);
    checkTxn(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    checkTxn(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0);
    checkTxn(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 2);
    checkTxn(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0);
    checkTxn(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 0);

    $display("[TB] CHUNK=32 and CHUNK=1 equality");
    checkAuxEqual(32'hDEAD_BEEF, 1'b0);
    checkAuxEqual(32'hDEAD_BEEF, 1'b1);

    $display("[TB] backpressure");
    applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b0);
    checkOutput("bp_eq", 32'(got_eq), 32'd0);
    checkOutput("bp_lt", 32'(got_lt), 32'd0);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        rs1d = 32'h0000_00AA; rs2d = 32'h0000_00AA; s = 1'b1; in_valid = 1'b1;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_eq_stable", 32'(eq), 32'd0);
      checkOutput("bp_lt_stable", 32'(lt), 32'd0);
    end
    releaseResult(0);
    checkTxn(32'h0000_0007, 32'h0000_0009, 1'b0, 0);

    $display("[TB] reset during compare");
    @(negedge clk);
    rs1d = 32'h0000_0001; rs2d = 32'h0000_0002; s = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_reset_eq", 32'(eq), 32'd0);
    checkOutput("async_reset_lt", 32'(lt), 32'd0);
    checkOutput("async_reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    checkTxn(32'h0000_0010, 32'h0000_0010, 1'b0, 0);

    $display("[TB] randomised back-to-back");
    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rb = ra;
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 3) == 0) rb[c*8 +: 8] = 8'($urandom);
      end
      if ($urandom_range(0, 4) == 0) rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      checkTxn(ra, rb, rs, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chunked_comparator.md
Name: chunked_comparator

Overview:
- Multi-cycle, parametrised successor to the single-cycle branch comparator.
- Compares two WIDTH-bit operands CHUNK bits per cycle, most-significant chunk first, and terminates early at the first differing chunk.
- Supports signed and unsigned modes and produces eq/lt.
- Sits behind a valid/ready handshake, so the wide-operand compare path (e.g. 64-bit or multi-word compares) runs off the critical path.

Parameters:
- WIDTH, 32, operand width in bits; must be an integer multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK, number of chunks.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept operands.
- rs1d  input  WIDTH  operand A.
- rs2d  input  WIDTH  operand B.
- s  input  1  1 = signed (two's complement) compare, 0 = unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- eq  output  1  A == B.
- lt  output  1  A < B under the selected mode.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, out_valid=0, eq=0, lt=0, in_ready=1, shift registers and chunk index cleared. Reset asserted mid-operation aborts it immediately; the in-flight result is discarded.
- State machine: IDLE -> CMP -> DONE -> IDLE.
- in_ready = (state==IDLE). out_valid = (state==DONE), registered.
- IDLE:
  - On in_valid && in_ready: latch rs1d/rs2d into shift registers A/B, set idx=NCHUNK-1, go to CMP.
  - If s=1, invert bit WIDTH-1 of both latched operands. This makes an unsigned compare equal to the signed compare.
- CMP: one chunk per cycle, comparing A[WIDTH-1 -: CHUNK] against B[WIDTH-1 -: CHUNK] unsigned.
  - Chunks differ: lt <= (A chunk < B chunk), eq <= 0, go to DONE.
  - Chunks equal and idx==0: eq <= 1, lt <= 0, go to DONE.
  - Otherwise: shift A and B left by CHUNK, idx <= idx-1, stay in CMP.
- Latency: operands accepted at edge E0. out_valid rises after edge Ej, where j = number of chunks examined (1..NCHUNK).
  - j = 1 if the top chunk differs.
  - j = NCHUNK for equal operands, or if only the bottom chunk differs.
- DONE:
  - eq/lt held stable while out_valid=1 && out_ready=0.
  - On out_ready: go to IDLE. in_ready asserts the cycle after the output handshake; there is no same-cycle accept.
- Inputs rs1d/rs2d/s/in_valid are ignored outside IDLE. eq/lt retain their last value after leaving DONE and are meaningful only while out_valid=1.
- CHUNK==WIDTH is the degenerate case: always exactly one CMP cycle.
- eq and lt are never both 1.
- Throughput: one compare per (j+2) cycles at best.

Test Plan:
- Unsigned early-exit vs. full scan (WIDTH=32, CHUNK=8):
  - s=0, rs1d=0x00000001, rs2d=0x00000002 -> out_valid 4 cycles after accept, lt=1, eq=0.
  - s=0, rs1d=0x02000000, rs2d=0x01000000 -> out_valid 1 cycle after accept, lt=0, eq=0.
- Signed vs. unsigned:
  - rs1d=0xFFFFFFFF, rs2d=0x00000001: s=1 -> lt=1 eq=0, latency 1; s=0 -> lt=0 eq=0.
  - rs1d=0x80000000, rs2d=0x7FFFFFFF: s=1 -> lt=1; s=0 -> lt=0.
- Equality: rs1d=rs2d=0xDEADBEEF, either s -> eq=1, lt=0, latency 4.
  - Repeat with CHUNK=32 -> latency 1.
  - Repeat with CHUNK=1 -> latency 32.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - out_valid, eq and lt stay constant; in_ready=0.
  - A new in_valid pulse with different operands is ignored.
  - Raising out_ready -> out_valid=0 next cycle and in_ready=1; the next operand pair then compares correctly.
- Reset mid-CMP: start 0x00000001 vs 0x00000002, pull reset_n low 2 cycles after accept.
  - Immediately (asynchronously) out_valid=0, eq=0, lt=0, in_ready=1.
  - After release, the next transaction 0x10 vs 0x10 -> eq=1.
- Randomised back-to-back: 100 random operand/mode pairs with random out_ready stalls.
  - eq/lt match $signed/unsigned reference results.
  - Latency equals 1 + (number of leading equal chunks), capped at NCHUNK.
